// File: rtl/wb_arbiter_pkg.sv
// Shared types and constants for the execute-to-scoreboard writeback arbiter.
// Slot and port records mirror the scoreboard fwd.wb[] element layout.
package wb_arbiter_pkg;

    localparam int SbIdxW = 3;

    localparam int WB_FLU   = 0;
    localparam int WB_MDU   = 1;
    localparam int WB_LOAD  = 2;
    localparam int WB_STORE = 3;

    typedef struct packed {
        logic              full;
        logic [SbIdxW-1:0] idx;
        logic [31:0]       data;
        logic              ex;
    } wb_slot_t;

    typedef struct packed {
        logic              valid;
        logic [SbIdxW-1:0] idx;
        logic [31:0]       data;
        logic              ex;
    } wb_port_t;

endpackage

// File: rtl/wb_arbiter_multi_grant.sv
// Combinational round-robin picker: grants the first NumWbPorts set bits
// of req scanning upward from ptr with wraparound.
module rr_multi_grant #(
    parameter int NumReq     = 4,
    parameter int NumWbPorts = 2,
    localparam int PtrW      = $clog2(NumReq),
    localparam int PortW     = (NumWbPorts > 1) ? $clog2(NumWbPorts) : 1
) (
    input  logic [NumReq-1:0]                    req,
    input  logic [PtrW-1:0]                      ptr,
    output logic [NumReq-1:0]                    grant,
    output logic [NumWbPorts-1:0]                port_valid,
    output logic [NumWbPorts-1:0][PtrW-1:0]      port_src,
    output logic [PtrW-1:0]                      next_ptr
);

    always_comb begin
        int               cnt;
        int               pos;
        logic [PtrW-1:0]  p;
        grant      = '0;
        port_valid = '0;
        port_src   = '0;
        next_ptr   = ptr;
        cnt        = 0;
        pos        = 0;
        p          = '0;
        for (int i = 0; i < NumReq; i++) begin
            pos = int'(ptr) + i;
            if (pos >= NumReq) pos = pos - NumReq;
            p = PtrW'(pos);
            if (req[p] && cnt < NumWbPorts) begin
                grant[p]                 = 1'b1;
                port_valid[PortW'(cnt)]  = 1'b1;
                port_src[PortW'(cnt)]    = p;
                cnt                      = cnt + 1;
                // pointer moves just past the most recent grant
                next_ptr = (pos == NumReq - 1) ? '0 : PtrW'(pos + 1);
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: one holding slot per FU result stream, up to
// NumWbPorts slots drained per cycle in round-robin order.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int NumReq     = 4,
    parameter int NumWbPorts = 2,
    parameter int IdxWidth   = SbIdxW,
    localparam int SrcW      = $clog2(NumReq)
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush,
    input  logic [NumReq-1:0]                     req_valid,
    output logic [NumReq-1:0]                     req_ready,
    input  logic [NumReq-1:0][IdxWidth-1:0]       req_idx,
    input  logic [NumReq-1:0][31:0]               req_data,
    input  logic [NumReq-1:0]                     req_ex,
    output logic [NumWbPorts-1:0]                 wb_valid,
    output logic [NumWbPorts-1:0][IdxWidth-1:0]   wb_idx,
    output logic [NumWbPorts-1:0][31:0]           wb_data,
    output logic [NumWbPorts-1:0]                 wb_ex,
    output logic [NumWbPorts-1:0][SrcW-1:0]       wb_src
);

    wb_slot_t                         slot [NumReq];
    logic [SrcW-1:0]                  ptr;
    logic [SrcW-1:0]                  next_ptr;
    logic [NumReq-1:0]                full;
    logic [NumReq-1:0]                grant;
    logic [NumReq-1:0]                accept;
    logic [NumWbPorts-1:0]            port_valid;
    logic [NumWbPorts-1:0][SrcW-1:0]  port_src;

    always_comb begin
        full = '0;
        for (int r = 0; r < NumReq; r++) full[r] = slot[r].full;
    end

    // grant never looks at req_valid, so ready has no path from valid
    assign req_ready = ~full | grant;
    assign accept    = req_valid & req_ready;

    rr_multi_grant #(
        .NumReq     (NumReq),
        .NumWbPorts (NumWbPorts)
    ) u_pick (
        .req        (full),
        .ptr        (ptr),
        .grant      (grant),
        .port_valid (port_valid),
        .port_src   (port_src),
        .next_ptr   (next_ptr)
    );

    always_comb begin
        wb_valid = '0;
        wb_idx   = '0;
        wb_data  = '0;
        wb_ex    = '0;
        wb_src   = '0;
        for (int k = 0; k < NumWbPorts; k++) begin
            if (port_valid[k]) begin
                wb_valid[k] = 1'b1;
                wb_idx[k]   = slot[port_src[k]].idx;
                wb_data[k]  = slot[port_src[k]].data;
                wb_ex[k]    = slot[port_src[k]].ex;
                wb_src[k]   = port_src[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int r = 0; r < NumReq; r++) slot[r] <= '0;
            ptr <= '0;
        end else begin
            for (int r = 0; r < NumReq; r++) begin
                if (accept[r]) begin
                    slot[r].full <= 1'b1;
                    slot[r].idx  <= req_idx[r];
                    slot[r].data <= req_data[r];
                    slot[r].ex   <= req_ex[r];
                end else if (grant[r]) begin
                    slot[r].full <= 1'b0;
                end
            end
            ptr <= next_ptr;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed vector table, a reset
// sequence, then random traffic against a slot-level reference model.
module tb_wb_arbiter;

    logic             clock = 1'b0;
    logic             reset;
    logic             flush;
    logic [3:0]       req_valid;
    logic [3:0]       req_ready;
    logic [3:0][2:0]  req_idx;
    logic [3:0][31:0] req_data;
    logic [3:0]       req_ex;
    logic [1:0]       wb_valid;
    logic [1:0][2:0]  wb_idx;
    logic [1:0][31:0] wb_data;
    logic [1:0]       wb_ex;
    logic [1:0][1:0]  wb_src;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    wb_arbiter dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_idx   (req_idx),
        .req_data  (req_data),
        .req_ex    (req_ex),
        .wb_valid  (wb_valid),
        .wb_idx    (wb_idx),
        .wb_data   (wb_data),
        .wb_ex     (wb_ex),
        .wb_src    (wb_src)
    );

    typedef struct {
        logic [3:0]  rv;
        logic        fl;
        logic [11:0] idx;
        logic [3:0]  e_rdy;
        logic [1:0]  e_v;
        logic [1:0]  e_s0;
        logic [1:0]  e_s1;
        logic [2:0]  e_i0;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(logic [3:0] rv, logic fl, logic [11:0] idx,
                                logic [3:0] rdy, logic [1:0] v,
                                logic [1:0] s0, logic [1:0] s1,
                                logic [2:0] i0);
        vec_t t;
        t.rv = rv; t.fl = fl; t.idx = idx; t.e_rdy = rdy;
        t.e_v = v; t.e_s0 = s0; t.e_s1 = s1; t.e_i0 = i0;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    // reference model state
    logic        m_full [4];
    logic [2:0]  m_idx  [4];
    logic [31:0] m_data [4];
    logic        m_ex   [4];
    int          m_ptr;

    initial begin
        vec_t v;
        int   e_cnt;
        int   e_src [2];
        logic [3:0] gnt;
        logic [3:0] e_rdy;

        reset = 1'b1; flush = 1'b0; req_valid = '0;
        req_idx = '0; req_data = '0; req_ex = '0;

        // idle, single result, contention, streaming, fairness, flush
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0010, 0, 12'h028, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b01, 1, 0, 5));
        vt.push_back(mk(4'b0000, 1, 12'h000, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b1111, 0, 12'h688, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b0011, 2'b11, 0, 1, 0));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b11, 2, 3, 2));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0001, 0, 12'h000, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0001, 0, 12'h001, 4'b1111, 2'b01, 0, 0, 0));
        vt.push_back(mk(4'b0001, 0, 12'h002, 4'b1111, 2'b01, 0, 0, 1));
        vt.push_back(mk(4'b0001, 0, 12'h003, 4'b1111, 2'b01, 0, 0, 2));
        vt.push_back(mk(4'b0000, 1, 12'h000, 4'b1111, 2'b01, 0, 0, 3));
        vt.push_back(mk(4'b0111, 0, 12'h088, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0111, 0, 12'h088, 4'b1011, 2'b11, 0, 1, 0));
        vt.push_back(mk(4'b0111, 0, 12'h088, 4'b1101, 2'b11, 2, 0, 2));
        vt.push_back(mk(4'b0111, 0, 12'h088, 4'b1110, 2'b11, 1, 2, 1));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1011, 2'b11, 0, 1, 0));
        vt.push_back(mk(4'b1100, 0, 12'hF80, 4'b1111, 2'b01, 2, 0, 2));
        vt.push_back(mk(4'b0001, 1, 12'h004, 4'b1111, 2'b11, 3, 2, 7));
        vt.push_back(mk(4'b1110, 0, 12'h688, 4'b1111, 2'b00, 0, 0, 0));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b0111, 2'b11, 1, 2, 1));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b01, 3, 0, 3));
        vt.push_back(mk(4'b0000, 0, 12'h000, 4'b1111, 2'b00, 0, 0, 0));

        repeat (2) @(negedge clock);
        reset = 1'b0;

        foreach (vt[i]) begin
            v = vt[i];
            @(negedge clock);
            req_valid = v.rv;
            flush     = v.fl;
            req_idx   = v.idx;
            req_data  = {4{32'hDEADBEEF}};
            req_ex    = '0;
            #1;
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(v.e_rdy));
            chk($sformatf("v%0d wb_valid", i), 32'(wb_valid), 32'(v.e_v));
            if (v.e_v[0]) begin
                chk($sformatf("v%0d src0", i), 32'(wb_src[0]), 32'(v.e_s0));
                chk($sformatf("v%0d idx0", i), 32'(wb_idx[0]), 32'(v.e_i0));
                chk($sformatf("v%0d data0", i), wb_data[0], 32'hDEADBEEF);
            end else begin
                chk($sformatf("v%0d idle0", i),
                    {wb_data[0] | 32'(wb_idx[0]) | 32'(wb_src[0]) | 32'(wb_ex[0])}, 0);
            end
            if (v.e_v[1]) begin
                chk($sformatf("v%0d src1", i), 32'(wb_src[1]), 32'(v.e_s1));
            end else begin
                chk($sformatf("v%0d idle1", i),
                    {wb_data[1] | 32'(wb_idx[1]) | 32'(wb_src[1]) | 32'(wb_ex[1])}, 0);
            end
        end

        // reset while slots are full drops everything
        @(negedge clock);
        flush = 1'b0; req_valid = 4'b1111; req_idx = 12'h688;
        @(negedge clock);
        req_valid = '0; reset = 1'b1;
        #1;
        chk("rst pre wb_valid", 32'(wb_valid), 32'h3);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("rst wb_valid", 32'(wb_valid), 0);
        chk("rst ready", 32'(req_ready), 32'hF);

        for (int r = 0; r < 4; r++) begin
            m_full[r] = 0; m_idx[r] = 0; m_data[r] = 0; m_ex[r] = 0;
        end
        m_ptr = 0;

        for (int c = 0; c < 400; c++) begin
            @(negedge clock);
            req_valid = 4'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            for (int r = 0; r < 4; r++) begin
                req_idx[r]  = 3'($urandom);
                req_data[r] = $urandom;
                req_ex[r]   = 1'($urandom);
            end
            // oldest-in-scan-order: rank full slots by distance from ptr
            e_cnt = 0; gnt = '0; e_src[0] = 0; e_src[1] = 0;
            for (int d = 0; d < 4; d++) begin
                int r;
                r = (m_ptr + d) % 4;
                if (m_full[r] && e_cnt < 2) begin
                    e_src[e_cnt] = r; gnt[r] = 1; e_cnt++;
                end
            end
            for (int r = 0; r < 4; r++) e_rdy[r] = !m_full[r] || gnt[r];
            #1;
            chk($sformatf("r%0d ready", c), 32'(req_ready), 32'(e_rdy));
            for (int k = 0; k < 2; k++) begin
                if (k < e_cnt) begin
                    chk($sformatf("r%0d v%0d", c, k), 32'(wb_valid[k]), 1);
                    chk($sformatf("r%0d src%0d", c, k), 32'(wb_src[k]), e_src[k]);
                    chk($sformatf("r%0d idx%0d", c, k), 32'(wb_idx[k]), 32'(m_idx[e_src[k]]));
                    chk($sformatf("r%0d data%0d", c, k), wb_data[k], m_data[e_src[k]]);
                    chk($sformatf("r%0d ex%0d", c, k), 32'(wb_ex[k]), 32'(m_ex[e_src[k]]));
                end else begin
                    chk($sformatf("r%0d idle%0d", c, k),
                        {wb_data[k] | 32'(wb_idx[k]) | 32'(wb_src[k]) |
                         32'(wb_ex[k]) | 32'(wb_valid[k])}, 0);
                end
            end
            if (flush) begin
                for (int r = 0; r < 4; r++) m_full[r] = 0;
                m_ptr = 0;
            end else begin
                for (int r = 0; r < 4; r++) begin
                    if (req_valid[r] && e_rdy[r]) begin
                        m_full[r] = 1; m_idx[r] = req_idx[r];
                        m_data[r] = req_data[r]; m_ex[r] = req_ex[r];
                    end else if (gnt[r]) begin
                        m_full[r] = 0;
                    end
                end
                if (e_cnt > 0) m_ptr = (e_src[e_cnt-1] + 1) % 4;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
# wb_arbiter

Writeback arbiter between the execute-stage functional units and the scoreboard. It accepts completed results from `NumReq` FU result streams into one-entry holding slots. Each cycle it grants up to `NumWbPorts` occupied slots, in round-robin order, onto the scoreboard writeback ports (`fwd.wb[]`). The issue stage forwards operands from these ports.

## Interface
- `NumReq`, default 4: number of FU result streams (0 FLU, 1 MDU, 2 LOAD, 3 STORE).
- `NumWbPorts`, default 2: equals `WriteBackPorts`; must be ≤ `NumReq`.
- `IdxWidth`, default 3: transaction-id width, `$clog2(ScoreboardDepth)`.

Ports:
- `clock`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `flush`, in, 1: discard all held results.
- `req_valid`, in, `[NumReq]`: FU result valid.
- `req_ready`, out, `[NumReq]`: slot can accept this cycle.
- `req_idx`, in, `[NumReq][IdxWidth]`: scoreboard index.
- `req_data`, in, `[NumReq][32]`: result data.
- `req_ex`, in, `[NumReq]`: result carries an exception.
- `wb_valid`, out, `[NumWbPorts]`: port valid.
- `wb_idx`, out, `[NumWbPorts][IdxWidth]`.
- `wb_data`, out, `[NumWbPorts][32]`.
- `wb_ex`, out, `[NumWbPorts]`.
- `wb_src`, out, `[NumWbPorts][$clog2(NumReq)]`: granted requester, for debug and verification.

## Operation
**Slots**
- One slot per requester: `full`, `idx`, `data`, `ex`.
- `req_ready[r] = !full[r] || grant[r]`.
- The grant depends only on slot state and the pointer, never on `req_valid`, so there is no combinational loop.
- Acceptance: `req_valid[r] && req_ready[r]` loads the slot at the clock edge.

**Arbitration**
- The candidate set is the full slots.
- Scan starts at pointer `ptr` and wraps modulo `NumReq`.
- The first `NumWbPorts` candidates in scan order are granted. The k-th grant drives port k.
- Unused ports have `wb_valid=0` and `idx/data/ex/src = 0`.
- Pointer update: if any grant occurred, `ptr <= (last granted index + 1) mod NumReq`. Otherwise `ptr` is held.
- Starvation bound: a full slot is granted within `ceil(NumReq/NumWbPorts)` cycles.

**Slot update per cycle**
- Granted and accepted in the same cycle: the slot stays full with the new contents.
- Granted and not accepted: the slot clears.
- Not granted: the slot holds (`ready=0`).

**Flush**
- All slots clear, and any acceptance in the same cycle is dropped.
- `wb_valid` remains combinationally driven from the pre-flush slots for that cycle. The scoreboard ignores writebacks during flush.
- `ptr` resets to 0.

**Other rules**
- `req_ex` is passed through unchanged. Stores complete with data as driven, which is don't-care for the scoreboard.
- No duplicate-idx checking; the scoreboard guarantees unique in-flight idx.

## Timing
- Latency: result accepted at edge N, visible on `wb_*` during cycle N+1. That is exactly one cycle when uncontended.
- `wb_*` are combinational from slot registers and `ptr`, with no input-to-output combinational path.
- Throughput: 1 result per requester per cycle when granted every cycle. Total is `NumWbPorts` results per cycle.
- Reset values:
  - all slots empty
  - `ptr=0`
  - `wb_valid=0`, `wb_idx/data/ex/src=0`
  - `req_ready=1` (all slots empty)
- Reset mid-operation discards all held results with no writeback in the following cycle.
- Simultaneous events:
  - `reset` has priority over `flush`, which has priority over grant/accept.
  - All `NumReq` slots full with `NumWbPorts=2` gives 2 grants per cycle, and the pointer rotates by the grant span.

## Structure
- Add to `OoO_pkg`:
  - `wb_slot_t` (packed: `full`, `idx`, `data`, `ex`)
  - `wb_port_t` (`valid`, `idx`, `data`, `ex`), matching the `fwd.wb[]` element type
  - FU request index constants `WB_FLU`, `WB_MDU`, `WB_LOAD`, `WB_STORE`
- Top `wb_arbiter` holds the slots and pointer.
- One sub-module, `rr_multi_grant`: a combinational rotate-and-pick of the first `NumWbPorts` set bits from `ptr`, outputting the grant vector, per-port source index, and next pointer.
- Do not use `rr_arb_tree`; it is single-grant only.

## Test plan
- **Reset then idle:** `req_ready=4'b1111` and `wb_valid=2'b00`.
- **Single result:** `req_valid[1]=1`, `idx=5`, `data=32'hDEADBEEF` at cycle 0 → cycle 1 shows `wb_valid[0]=1`, `wb_idx[0]=5`, `wb_data[0]=DEADBEEF`, `wb_src[0]=1`. Then `ptr=2`.
- **Contention:**
  - Load all 4 slots in one cycle (idx 0..3) with `ptr=0`.
  - Next cycle: ports carry src 0,1, `req_ready=4'b0011`.
  - Following cycle: src 2,3. Then all empty.
- **Back-to-back streaming:** FLU `valid=1` every cycle with idx 0,1,2,…, no other requesters → one writeback per cycle, consecutive idx, `req_ready[0]` stays 1.
- **Fairness:**
  - Slots 0,1,2 held full continuously with new results.
  - Over 3 cycles each source is granted exactly twice.
  - Grant pattern is {0,1}, {2,0}, {1,2}.
- **Flush:**
  - Slots 2,3 full and `req_valid[0]=1` during a flush cycle.
  - Next cycle: `wb_valid=0`, `req_ready=4'b1111`, `ptr=0`, and the idx from requester 0 is never written back.
